// File: rtl/shop_if.sv
// Host-to-shop command bus.
//   i_rdy : command strobe; a rising edge launches one command
//   i_u   : user id or item id operand
//   i_a   : right-justified ASCII command word
//   o_a   : right-justified ASCII status word returned by the shop
// master modport is the host side, slave modport is the shop back-end.
interface shop_if #(
  parameter int I_A_NUM_BITS = 56,
  parameter int O_A_NUM_BITS = 72,
  parameter int I_U_NUM_BITS = 4
);
  logic                    i_rdy;
  logic [I_U_NUM_BITS-1:0] i_u;
  logic [I_A_NUM_BITS-1:0] i_a;
  logic [O_A_NUM_BITS-1:0] o_a;

  modport master (output i_rdy, output i_u, output i_a, input o_a);
  modport slave  (input i_rdy, input i_u, input i_a, output o_a);
endinterface

// File: rtl/shop.sv
// Shop back-end command processor: user table, per-item stock counters and
// a single login session. One command executes per rising edge of i_rdy;
// its status word appears on o_a after that clock edge and holds until the
// next command.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous, active-low reset
//   bus     : shop_if.slave (i_rdy, i_u, i_a in; o_a out)
// Optional build macro SHOP_STOCK_QUERY_EN adds the "Stock" query command,
// answering "STOCK=nn" to any logged-in user.
module shop #(
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
  parameter int O_A_NUM_BITS        = O_A_NUM_ASCII_CHARS * 8,
  parameter int I_U_NUM_BITS        = 4,
  parameter int MAX_USERS           = 5,
  parameter int NUM_ITEMS           = 16,
  parameter int STOCK_BITS          = 4,
  parameter CMD_KEY__LOGOUT         = "Logout",
  parameter CMD_KEY__LOGIN          = "Login",
  parameter CMD_KEY__ADD_USER       = "AddUsr",
  parameter CMD_KEY__DELETE_USER    = "DelUsr",
  parameter CMD_KEY__ADD_ITEM       = "AddItem",
  parameter CMD_KEY__DELETE_ITEM    = "DelItem",
  parameter CMD_KEY__BUY            = "Buy",
  parameter CMD_KEY__NONE           = "NONE"
`ifdef SHOP_STOCK_QUERY_EN
  , parameter CMD_KEY__STOCK        = "Stock"
`endif
) (
  input  logic  i_clk,
  input  logic  i_reset,
  shop_if.slave bus
);

  typedef logic [I_A_NUM_BITS-1:0] cmd_t;
  typedef logic [O_A_NUM_BITS-1:0] msg_t;
  typedef logic [STOCK_BITS-1:0]   cnt_t;

  localparam cmd_t K_LOGOUT = I_A_NUM_BITS'(CMD_KEY__LOGOUT);
  localparam cmd_t K_LOGIN  = I_A_NUM_BITS'(CMD_KEY__LOGIN);
  localparam cmd_t K_ADDUSR = I_A_NUM_BITS'(CMD_KEY__ADD_USER);
  localparam cmd_t K_DELUSR = I_A_NUM_BITS'(CMD_KEY__DELETE_USER);
  localparam cmd_t K_ADDITM = I_A_NUM_BITS'(CMD_KEY__ADD_ITEM);
  localparam cmd_t K_DELITM = I_A_NUM_BITS'(CMD_KEY__DELETE_ITEM);
  localparam cmd_t K_BUY    = I_A_NUM_BITS'(CMD_KEY__BUY);
  // "NONE" is a reserved key with no action, so it falls through to BAD_CMD.
  localparam cmd_t K_NONE   = I_A_NUM_BITS'(CMD_KEY__NONE);
`ifdef SHOP_STOCK_QUERY_EN
  localparam cmd_t K_STOCK  = I_A_NUM_BITS'(CMD_KEY__STOCK);
`endif

  localparam msg_t S_READY    = O_A_NUM_BITS'("READY");
  localparam msg_t S_OK       = O_A_NUM_BITS'("OK");
  localparam msg_t S_BUSY     = O_A_NUM_BITS'("BUSY");
  localparam msg_t S_NO_USER  = O_A_NUM_BITS'("NO_USER");
  localparam msg_t S_NO_LOGIN = O_A_NUM_BITS'("NO_LOGIN");
  localparam msg_t S_DENIED   = O_A_NUM_BITS'("DENIED");
  localparam msg_t S_EXISTS   = O_A_NUM_BITS'("EXISTS");
  localparam msg_t S_NO_ITEM  = O_A_NUM_BITS'("NO_ITEM");
  localparam msg_t S_FULL     = O_A_NUM_BITS'("FULL");
  localparam msg_t S_NO_STOCK = O_A_NUM_BITS'("NO_STOCK");
  localparam msg_t S_BAD_CMD  = O_A_NUM_BITS'("BAD_CMD");

  // Saturating stock counter steps; callers already reject the saturated case.
  function automatic cnt_t stock_inc(input cnt_t c);
    return (c == '1) ? c : c + STOCK_BITS'(1);
  endfunction

  function automatic cnt_t stock_dec(input cnt_t c);
    return (c == '0) ? c : c - STOCK_BITS'(1);
  endfunction

`ifdef SHOP_STOCK_QUERY_EN
  function automatic msg_t stock_msg(input cnt_t c);
    int         n;
    logic [7:0] tens;
    logic [7:0] ones;
    n    = int'(c);
    tens = 8'(48 + (n / 10) % 10);
    ones = 8'(48 + n % 10);
    return O_A_NUM_BITS'({"STOCK=", tens, ones});
  endfunction
`endif

  logic                    rdy_q, rdy_d;
  logic [MAX_USERS-1:0]    valid_q, valid_d;
  logic                    logged_q, logged_d;
  logic [I_U_NUM_BITS-1:0] sess_q, sess_d;
  cnt_t                    stock_q [NUM_ITEMS];
  cnt_t                    stock_d [NUM_ITEMS];
  msg_t                    o_a_q, o_a_d;

  cmd_t cmd;
  int   uid;
  logic fire;
  logic is_admin;
  logic user_on;
  cnt_t cur_stock;
  logic stk_we;
  cnt_t stk_new;
  logic usr_we;
  logic usr_new;

  assign cmd     = bus.i_a;
  assign bus.o_a = o_a_q;

  always_comb begin
    rdy_d   = bus.i_rdy;
    valid_d = valid_q;
    logged_d = logged_q;
    sess_d  = sess_q;
    stock_d = stock_q;
    o_a_d   = o_a_q;
    stk_we  = 1'b0;
    usr_we  = 1'b0;
    usr_new = 1'b0;

    fire     = bus.i_rdy && !rdy_q;
    is_admin = logged_q && (sess_q == '0);
    uid      = int'(bus.i_u);

    // Operand lookups; out-of-range ids read as absent user / empty item.
    user_on = 1'b0;
    for (int k = 0; k < MAX_USERS; k++)
      if (uid == k) user_on = valid_q[k];
    cur_stock = '0;
    for (int k = 0; k < NUM_ITEMS; k++)
      if (uid == k) cur_stock = stock_q[k];
    stk_new = cur_stock;

    if (fire) begin
      if (cmd == K_LOGIN) begin
        if (logged_q) o_a_d = S_BUSY;
        else if (uid < MAX_USERS && user_on) begin
          logged_d = 1'b1;
          sess_d   = bus.i_u;
          o_a_d    = S_OK;
        end else o_a_d = S_NO_USER;
      end else if (cmd == K_LOGOUT) begin
        if (logged_q) begin
          logged_d = 1'b0;
          sess_d   = '0;
          o_a_d    = S_OK;
        end else o_a_d = S_NO_LOGIN;
      end else if (cmd == K_ADDUSR) begin
        if (!is_admin) o_a_d = S_DENIED;
        else if (uid == 0 || uid >= MAX_USERS) o_a_d = S_NO_USER;
        else if (user_on) o_a_d = S_EXISTS;
        else begin
          usr_we  = 1'b1;
          usr_new = 1'b1;
          o_a_d   = S_OK;
        end
      end else if (cmd == K_DELUSR) begin
        // Only admin can reach this and id 0 is refused, so the logged-in
        // user is never deleted.
        if (!is_admin) o_a_d = S_DENIED;
        else if (uid == 0 || uid >= MAX_USERS || !user_on) o_a_d = S_NO_USER;
        else begin
          usr_we = 1'b1;
          o_a_d  = S_OK;
        end
      end else if (cmd == K_ADDITM) begin
        if (!is_admin) o_a_d = S_DENIED;
        else if (uid >= NUM_ITEMS) o_a_d = S_NO_ITEM;
        else if (cur_stock == '1) o_a_d = S_FULL;
        else begin
          stk_we  = 1'b1;
          stk_new = stock_inc(cur_stock);
          o_a_d   = S_OK;
        end
      end else if (cmd == K_DELITM) begin
        if (!is_admin) o_a_d = S_DENIED;
        else if (uid >= NUM_ITEMS) o_a_d = S_NO_ITEM;
        else if (cur_stock == '0) o_a_d = S_NO_STOCK;
        else begin
          stk_we  = 1'b1;
          stk_new = stock_dec(cur_stock);
          o_a_d   = S_OK;
        end
      end else if (cmd == K_BUY) begin
        if (!logged_q || is_admin) o_a_d = S_DENIED;
        else if (uid >= NUM_ITEMS) o_a_d = S_NO_ITEM;
        else if (cur_stock == '0) o_a_d = S_NO_STOCK;
        else begin
          stk_we  = 1'b1;
          stk_new = stock_dec(cur_stock);
          o_a_d   = S_OK;
        end
`ifdef SHOP_STOCK_QUERY_EN
      end else if (cmd == K_STOCK) begin
        if (!logged_q) o_a_d = S_DENIED;
        else if (uid >= NUM_ITEMS) o_a_d = S_NO_ITEM;
        else o_a_d = stock_msg(cur_stock);
`endif
      end else if (cmd == K_NONE) begin
        o_a_d = S_BAD_CMD;
      end else begin
        o_a_d = S_BAD_CMD;
      end
    end

    for (int k = 0; k < MAX_USERS; k++)
      if (usr_we && uid == k) valid_d[k] = usr_new;
    for (int k = 0; k < NUM_ITEMS; k++)
      if (stk_we && uid == k) stock_d[k] = stk_new;
  end

  // State register stage: tables, session and status word update together.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rdy_q    <= 1'b0;
      valid_q  <= MAX_USERS'(1);
      logged_q <= 1'b0;
      sess_q   <= '0;
      o_a_q    <= S_READY;
      for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= '0;
    end else begin
      rdy_q    <= rdy_d;
      valid_q  <= valid_d;
      logged_q <= logged_d;
      sess_q   <= sess_d;
      o_a_q    <= o_a_d;
      stock_q  <= stock_d;
    end
  end

endmodule

// File: tb/tb_shop.sv
// Testbench for shop: directed walk through the shop scenarios, then a long
// randomized command stream scored against a behavioural model of the shop
// rules (user list, session, stock table). Item ids up to 31 are driven so
// that out-of-range items are reachable; the DUT is built with a 5-bit i_u.
module tb_shop;
  localparam int IA = 56;
  localparam int OA = 72;
  localparam int IU = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  shop_if #(.I_A_NUM_BITS(IA), .O_A_NUM_BITS(OA), .I_U_NUM_BITS(IU)) bus ();

  shop #(.I_U_NUM_BITS(IU)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [IA-1:0] C_LOGIN  = IA'("Login");
  localparam logic [IA-1:0] C_LOGOUT = IA'("Logout");
  localparam logic [IA-1:0] C_ADDUSR = IA'("AddUsr");
  localparam logic [IA-1:0] C_DELUSR = IA'("DelUsr");
  localparam logic [IA-1:0] C_ADDITM = IA'("AddItem");
  localparam logic [IA-1:0] C_DELITM = IA'("DelItem");
  localparam logic [IA-1:0] C_BUY    = IA'("Buy");
  localparam logic [IA-1:0] C_STOCK  = IA'("Stock");
  localparam logic [IA-1:0] C_NONE   = IA'("NONE");
  localparam logic [IA-1:0] C_HI     = IA'("hi");

  // Behavioural shop model
  bit m_user [5];
  bit m_logged;
  int m_sess;
  int m_stock [16];

  function automatic void model_reset();
    foreach (m_user[k]) m_user[k] = (k == 0);
    m_logged = 1'b0;
    m_sess   = 0;
    foreach (m_stock[k]) m_stock[k] = 0;
  endfunction

  function automatic logic [OA-1:0] model_exec(input logic [IA-1:0] c, input int u);
    bit admin;
    admin = m_logged && m_sess == 0;
    if (c == C_LOGIN) begin
      if (m_logged) return OA'("BUSY");
      if (u < 5 && m_user[u]) begin m_logged = 1; m_sess = u; return OA'("OK"); end
      return OA'("NO_USER");
    end
    if (c == C_LOGOUT) begin
      if (!m_logged) return OA'("NO_LOGIN");
      m_logged = 0; return OA'("OK");
    end
    if (c == C_ADDUSR || c == C_DELUSR || c == C_ADDITM || c == C_DELITM)
      if (!admin) return OA'("DENIED");
    if (c == C_ADDUSR) begin
      if (u == 0 || u >= 5) return OA'("NO_USER");
      if (m_user[u]) return OA'("EXISTS");
      m_user[u] = 1; return OA'("OK");
    end
    if (c == C_DELUSR) begin
      if (u == 0 || u >= 5 || !m_user[u]) return OA'("NO_USER");
      m_user[u] = 0; return OA'("OK");
    end
    if (c == C_BUY && (!m_logged || admin)) return OA'("DENIED");
`ifdef SHOP_STOCK_QUERY_EN
    if (c == C_STOCK) begin
      if (!m_logged) return OA'("DENIED");
      if (u >= 16) return OA'("NO_ITEM");
      return OA'({"STOCK=", 8'(48 + m_stock[u] / 10), 8'(48 + m_stock[u] % 10)});
    end
`endif
    if (c == C_ADDITM || c == C_DELITM || c == C_BUY) begin
      if (u >= 16) return OA'("NO_ITEM");
      if (c == C_ADDITM) begin
        if (m_stock[u] == 15) return OA'("FULL");
        m_stock[u]++; return OA'("OK");
      end
      if (m_stock[u] == 0) return OA'("NO_STOCK");
      m_stock[u]--; return OA'("OK");
    end
    return OA'("BAD_CMD");
  endfunction

  task automatic check(input string tag, input logic [OA-1:0] obs, input logic [OA-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [IA-1:0] c, input int u);
    @(negedge clk);
    bus.i_a   = c;
    bus.i_u   = IU'(u);
    bus.i_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_rdy();
    @(negedge clk);
    bus.i_rdy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Directed step: DUT answer must match the literal expected status.
  task automatic step(input string tag, input logic [IA-1:0] c, input int u,
                      input logic [OA-1:0] lit);
    logic [OA-1:0] m;
    issue(c, u);
    m = model_exec(c, u);
    check(tag, bus.o_a, lit);
    drop_rdy();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic [OA-1:0] exp;
    logic [IA-1:0] c;
    int            u;
    int            sel;

    rst_n     = 1'b0;
    bus.i_rdy = 1'b0;
    bus.i_a   = '0;
    bus.i_u   = '0;
    do_reset(4);
    check("reset_hold", bus.o_a, OA'("READY"));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", bus.o_a, OA'("READY"));

    step("login4_nouser",   C_LOGIN,  4, OA'("NO_USER"));
    step("additem_nosess",  C_ADDITM, 5, OA'("DENIED"));
    step("login6_nouser",   C_LOGIN,  6, OA'("NO_USER"));
    step("bad_cmd_hi",      C_HI,     0, OA'("BAD_CMD"));
    step("none_bad",        C_NONE,   0, OA'("BAD_CMD"));
    step("login0_ok",       C_LOGIN,  0, OA'("OK"));
    step("login0_busy",     C_LOGIN,  0, OA'("BUSY"));
    step("addusr4_ok",      C_ADDUSR, 4, OA'("OK"));
    step("addusr4_exists",  C_ADDUSR, 4, OA'("EXISTS"));
    step("addusr5_nouser",  C_ADDUSR, 5, OA'("NO_USER"));
    step("additem5_a",      C_ADDITM, 5, OA'("OK"));
    step("additem5_b",      C_ADDITM, 5, OA'("OK"));
    step("logout_ok",       C_LOGOUT, 0, OA'("OK"));
    step("logout_nologin",  C_LOGOUT, 0, OA'("NO_LOGIN"));
    step("login4_ok",       C_LOGIN,  4, OA'("OK"));
    step("buy5_a",          C_BUY,    5, OA'("OK"));
    step("buy5_b",          C_BUY,    5, OA'("OK"));
    step("buy5_nostock",    C_BUY,    5, OA'("NO_STOCK"));
    step("buy16_noitem",    C_BUY,   16, OA'("NO_ITEM"));
    step("user_additem",    C_ADDITM, 5, OA'("DENIED"));
    step("user_addusr",     C_ADDUSR, 3, OA'("DENIED"));
    step("logout4",         C_LOGOUT, 0, OA'("OK"));
    step("admin_login",     C_LOGIN,  0, OA'("OK"));
    step("admin_buy",       C_BUY,    3, OA'("DENIED"));
    for (int i = 0; i < 15; i++) step("additem3_fill", C_ADDITM, 3, OA'("OK"));
    step("additem3_full",   C_ADDITM, 3, OA'("FULL"));
    step("delitem3_ok",     C_DELITM, 3, OA'("OK"));
    step("delitem7_empty",  C_DELITM, 7, OA'("NO_STOCK"));
    step("additem20_noitem", C_ADDITM, 20, OA'("NO_ITEM"));
    step("delusr0_nouser",  C_DELUSR, 0, OA'("NO_USER"));
    step("delusr4_ok",      C_DELUSR, 4, OA'("OK"));
    step("delusr4_gone",    C_DELUSR, 4, OA'("NO_USER"));
    step("logout_admin",    C_LOGOUT, 0, OA'("OK"));
    step("login4_deleted",  C_LOGIN,  4, OA'("NO_USER"));
    step("admin_again",     C_LOGIN,  0, OA'("OK"));
`ifndef SHOP_STOCK_QUERY_EN
    step("stock_disabled",  C_STOCK,  3, OA'("BAD_CMD"));
`else
    step("stock_query",     C_STOCK,  3, OA'("STOCK=14"));
`endif

    // i_rdy held high: one execution only (stock 14 -> 15), o_a holds.
    issue(C_ADDITM, 3);
    exp = model_exec(C_ADDITM, 3);
    check("hold_first", bus.o_a, OA'("OK"));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hold_no_refire", bus.o_a, OA'("OK"));
    end
    drop_rdy();
    check("hold_after_drop", bus.o_a, exp);
    step("hold_then_full",  C_ADDITM, 3, OA'("FULL"));

    // Reset mid-session with a command strobed on the reset edge.
    step("addusr2_ok",      C_ADDUSR, 2, OA'("OK"));
    @(negedge clk);
    rst_n     = 1'b0;
    bus.i_a   = C_LOGOUT;
    bus.i_rdy = 1'b1;
    @(posedge clk); #1;
    check("reset_overrides_cmd", bus.o_a, OA'("READY"));
    bus.i_rdy = 1'b0;
    do_reset(2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_ready", bus.o_a, OA'("READY"));
    step("post_rst_nologin", C_LOGOUT, 0, OA'("NO_LOGIN"));
    step("post_rst_user2",   C_LOGIN,  2, OA'("NO_USER"));
    step("post_rst_admin",   C_LOGIN,  0, OA'("OK"));
    step("post_rst_stock0",  C_DELITM, 3, OA'("NO_STOCK"));

    // Randomized command stream against the model.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    c = C_LOGIN;
        2:       c = C_LOGOUT;
        3:       c = C_ADDUSR;
        4:       c = C_DELUSR;
        5, 6:    c = C_ADDITM;
        7:       c = C_DELITM;
        8, 9:    c = C_BUY;
        10:      c = C_STOCK;
        default: c = ($urandom_range(0, 1) == 0) ? C_NONE : IA'({$urandom, $urandom});
      endcase
      u = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      issue(c, u);
      exp = model_exec(c, u);
      check("rand_cmd", bus.o_a, exp);
      drop_rdy();
      if (i % 50 == 0) check("rand_hold", bus.o_a, exp);
      if (i == 300) begin
        do_reset(1);
        check("rand_reset", bus.o_a, OA'("READY"));
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shop.md
Name: shop

Overview:
- Single-clock command processor for a small shop database: user table, per-item stock counters and one login session.
- Commands arrive as right-justified ASCII strings on i_a, qualified by an i_rdy pulse; i_u carries the user or item number.
- Each command produces a right-justified ASCII status word on o_a.
- Sits behind a host/console interface as the shop back-end.

Parameters:
- I_A_NUM_ASCII_CHARS, 7: command width in chars; must fit the longest CMD_KEY.
- O_A_NUM_ASCII_CHARS, 9: response width in chars.
- I_A_NUM_BITS, I_A_NUM_ASCII_CHARS*8: i_a width.
- O_A_NUM_BITS, O_A_NUM_ASCII_CHARS*8: o_a width.
- I_U_NUM_BITS, 4: i_u width; max 15.
- MAX_USERS, 5: user slots including admin (id 0).
- NUM_ITEMS, 16: item ids 0..NUM_ITEMS-1.
- STOCK_BITS, 4: per-item counter width.
- CMD_KEY__LOGOUT, "Logout"; CMD_KEY__LOGIN, "Login"; CMD_KEY__ADD_USER, "AddUsr"; CMD_KEY__DELETE_USER, "DelUsr"; CMD_KEY__ADD_ITEM, "AddItem"; CMD_KEY__DELETE_ITEM, "DelItem"; CMD_KEY__BUY, "Buy"; CMD_KEY__NONE, "NONE": command strings.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_rdy  in  1  command strobe; its rising edge launches one command.
- i_u  in  I_U_NUM_BITS  unsigned user id or item id operand.
- i_a  in  I_A_NUM_BITS  ASCII command, right-justified, zero-padded in upper bytes.
- o_a  out  O_A_NUM_BITS  ASCII status, right-justified, zero-padded.

Behaviour:
- Reset (i_reset==0 at a rising edge):
  - user table: only admin id 0 valid.
  - session: nobody logged in.
  - all stock counters 0.
  - i_rdy edge register cleared.
  - o_a = "READY".
  - Reset overrides any command sampled on the same edge.
- Handshake:
  - rdy_q registers i_rdy each edge.
  - Command fires on an edge where i_rdy==1 and rdy_q==0.
  - i_a and i_u are sampled on that edge.
  - o_a is updated on the same edge, i.e. visible one edge after i_rdy rises.
  - Holding i_rdy high executes only once.
  - o_a holds its value until the next command.
- Decode: exact full-width compare of i_a against each zero-extended CMD_KEY. No match (including "NONE") -> "BAD_CMD", no state change.
- Login:
  - If already logged in -> "BUSY".
  - Else if i_u<MAX_USERS and the user is valid -> session=i_u, "OK".
  - Else -> "NO_USER".
- Logout: if logged in -> clear session, "OK"; else "NO_LOGIN".
- Admin-only commands (AddUsr, DelUsr, AddItem, DelItem): if the session is not admin -> "DENIED", no change.
- AddUsr:
  - i_u==0 or i_u>=MAX_USERS -> "NO_USER".
  - Already valid -> "EXISTS".
  - Else set valid, "OK".
- DelUsr:
  - i_u==0, i_u>=MAX_USERS, or not valid -> "NO_USER".
  - Else clear valid, "OK".
  - Never deletes a logged-in user; only admin can issue it, and admin is undeletable.
- Item id check for AddItem, DelItem, Buy: i_u>=NUM_ITEMS -> "NO_ITEM".
- AddItem: stock==2^STOCK_BITS-1 -> "FULL" (saturate); else stock+1, "OK".
- DelItem: stock==0 -> "NO_STOCK"; else stock-1, "OK".
- Buy:
  - Session empty or admin -> "DENIED".
  - Stock==0 -> "NO_STOCK".
  - Else stock-1, "OK".
- Priority per command: reset > decode > permission > range > state checks.
- Status strings are at most 9 chars, all fitting O_A_NUM_BITS.
- Arithmetic: unsigned; no wrap on stock counters.

Optional Feature:
- Macro: SHOP_STOCK_QUERY_EN.
- When defined:
  - Extra parameter CMD_KEY__STOCK = "Stock".
  - Any logged-in user (including admin) may query item i_u.
  - o_a = "STOCK=" followed by two ASCII decimal digits of the count, e.g. "STOCK=07".
  - Not logged in -> "DENIED"; bad id -> "NO_ITEM".
- When undefined: "Stock" decodes as unknown -> "BAD_CMD".

Test Plan:
- Hold i_reset low 4 clocks, release -> o_a=="READY". Then Login, i_u=4 -> "NO_USER".
- AddItem, i_u=5, with no session -> "DENIED". Login 6 -> "NO_USER". i_a="hi" -> "BAD_CMD".
- Login 0 -> "OK"; Login 0 again -> "BUSY"; AddUsr 4 -> "OK"; AddUsr 4 -> "EXISTS"; AddUsr 5 -> "NO_USER"; AddItem 5 twice -> "OK","OK"; Logout -> "OK"; Logout -> "NO_LOGIN".
- Login 4; Buy 5 three times -> "OK","OK","NO_STOCK"; Buy 16 -> "NO_ITEM"; AddItem 5 -> "DENIED".
- Admin: AddItem 3 sixteen times -> fifteen "OK", then "FULL"; DelItem 3 -> "OK"; DelUsr 0 -> "NO_USER"; DelUsr 4 -> "OK", after which Login 4 -> "NO_USER".
- Hold i_rdy high 5 clocks with AddItem -> stock +1 only. Assert reset mid-session -> "READY", session cleared, stock 0, user 4 gone.
